// File: rtl/miner_scheduler.sv
// Hands out nonce ranges round-robin to a pool of miners and collects the first winning result.
// Outcomes are a found result, an exhausted dispatch budget, or an abort.
module miner_scheduler #(
    parameter int unsigned NUM_MINERS = 4,
    parameter int unsigned NONCE_W    = 192,
    parameter int unsigned HASH_W     = 256
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            Start_I,
    input  logic                            Abort_I,
    input  logic [NONCE_W-1:0]              BaseNonce_I,
    input  logic [31:0]                     Step_I,
    input  logic [31:0]                     MaxDispatch_I,
    output logic [NUM_MINERS-1:0]           MinerStart_O,
    output logic [NONCE_W-1:0]              MinerNonce_O,
    output logic                            MinerClear_O,
    input  logic [NUM_MINERS-1:0]           MinerDone_I,
    input  logic [NUM_MINERS-1:0]           MinerFound_I,
    input  logic [NUM_MINERS*NONCE_W-1:0]   MinerNonceRes_I,
    input  logic [NUM_MINERS*HASH_W-1:0]    MinerHashRes_I,
    output logic                            Found_O,
    output logic [NONCE_W-1:0]              FoundNonce_O,
    output logic [HASH_W-1:0]               FoundHash_O,
    output logic                            Busy_O,
    output logic [31:0]                     DispatchCount_O,
    output logic                            Irq_O
);

    localparam int unsigned PTR_W = (NUM_MINERS > 1) ? $clog2(NUM_MINERS) : 1;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t               state;
    logic                 armed;
    logic [NONCE_W-1:0]   next_nonce;
    logic [CNT_W-1:0]     step;
    logic [CNT_W-1:0]     max_disp;
    logic [NUM_MINERS-1:0] busy;
    logic [PTR_W-1:0]     rr_ptr;

    logic [NUM_MINERS-1:0] found_hit;
    logic [NUM_MINERS-1:0] busy_left;
    logic                  pick_valid;
    logic [PTR_W-1:0]      pick_idx;
    logic                  sel_valid;
    logic [NONCE_W-1:0]    sel_nonce;
    logic [HASH_W-1:0]     sel_hash;
    logic                  limit_hit;
    logic                  dispatch;
    logic [CNT_W-1:0]      cnt_inc;
    logic [PTR_W-1:0]      ptr_next;

    // A done pulse only counts for a miner we believe is working.
    assign found_hit = MinerDone_I & MinerFound_I & busy;
    assign busy_left = busy & ~MinerDone_I;
    assign limit_hit = (max_disp != '0) && (DispatchCount_O >= max_disp);
    assign cnt_inc   = (DispatchCount_O == '1) ? DispatchCount_O : DispatchCount_O + CNT_W'(1);
    assign ptr_next  = (pick_idx == PTR_W'(NUM_MINERS - 1)) ? '0 : pick_idx + PTR_W'(1);

    // Round-robin search uses registered busy bits, so a miner freed this edge waits one cycle.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned off = 0; off < NUM_MINERS; off++) begin
            logic [PTR_W-1:0] idx;
            idx = PTR_W'((32'(rr_ptr) + off) % NUM_MINERS);
            if (!pick_valid && !busy[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    // Lowest-index winner among simultaneous finds.
    always_comb begin
        sel_valid = 1'b0;
        sel_nonce = '0;
        sel_hash  = '0;
        for (int i = 0; i < NUM_MINERS; i++) begin
            if (found_hit[i] && !sel_valid) begin
                sel_valid = 1'b1;
                sel_nonce = MinerNonceRes_I[i*NONCE_W +: NONCE_W];
                sel_hash  = MinerHashRes_I[i*HASH_W +: HASH_W];
            end
        end
    end

    assign dispatch = (state == S_RUN) && armed && pick_valid && !limit_hit && !sel_valid;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= S_IDLE;
            armed           <= 1'b0;
            next_nonce      <= '0;
            step            <= '0;
            max_disp        <= '0;
            busy            <= '0;
            rr_ptr          <= '0;
            MinerStart_O    <= '0;
            MinerNonce_O    <= '0;
            MinerClear_O    <= 1'b0;
            Found_O         <= 1'b0;
            FoundNonce_O    <= '0;
            FoundHash_O     <= '0;
            Busy_O          <= 1'b0;
            DispatchCount_O <= '0;
            Irq_O           <= 1'b0;
        end else begin
            MinerStart_O <= '0;
            MinerClear_O <= 1'b0;
            Found_O      <= 1'b0;
            if (Abort_I) begin
                state        <= S_IDLE;
                armed        <= 1'b0;
                busy         <= '0;
                MinerClear_O <= 1'b1;
                Busy_O       <= 1'b0;
                Irq_O        <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (Start_I) begin
                            state           <= S_RUN;
                            armed           <= 1'b0;
                            next_nonce      <= BaseNonce_I;
                            step            <= Step_I;
                            max_disp        <= MaxDispatch_I;
                            DispatchCount_O <= '0;
                            busy            <= '0;
                            Busy_O          <= 1'b1;
                            Irq_O           <= 1'b0;
                        end
                    end
                    S_RUN, S_DRAIN: begin
                        armed <= 1'b1;
                        busy  <= busy_left;
                        if (sel_valid) begin
                            state        <= S_DONE;
                            Found_O      <= 1'b1;
                            FoundNonce_O <= sel_nonce;
                            FoundHash_O  <= sel_hash;
                            Irq_O        <= 1'b1;
                            MinerClear_O <= 1'b1;
                            Busy_O       <= 1'b0;
                        end else if (state == S_DRAIN) begin
                            if (busy_left == '0) begin
                                state        <= S_DONE;
                                Irq_O        <= 1'b1;
                                MinerClear_O <= 1'b1;
                                Busy_O       <= 1'b0;
                            end
                        end else if (dispatch) begin
                            MinerStart_O    <= NUM_MINERS'(1) << pick_idx;
                            MinerNonce_O    <= next_nonce;
                            busy            <= busy_left | (NUM_MINERS'(1) << pick_idx);
                            next_nonce      <= next_nonce + NONCE_W'(step);
                            DispatchCount_O <= cnt_inc;
                            rr_ptr          <= ptr_next;
                            if ((max_disp != '0) && (cnt_inc >= max_disp)) begin
                                state <= S_DRAIN;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_miner_scheduler.sv
// Directed bench for miner_scheduler; expected dispatches are queued as stimulus is applied
// and popped whenever the scheduler issues a MinerStart_O pulse.
module tb_miner_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned NW = 192;
    localparam int unsigned HW = 256;

    typedef struct packed {
        logic [N-1:0]  start;
        logic [NW-1:0] nonce;
    } disp_t;

    logic              Clk;
    logic              Rst;
    logic              Start_I;
    logic              Abort_I;
    logic [NW-1:0]     BaseNonce_I;
    logic [31:0]       Step_I;
    logic [31:0]       MaxDispatch_I;
    logic [N-1:0]      MinerStart_O;
    logic [NW-1:0]     MinerNonce_O;
    logic              MinerClear_O;
    logic [N-1:0]      MinerDone_I;
    logic [N-1:0]      MinerFound_I;
    logic [N*NW-1:0]   MinerNonceRes_I;
    logic [N*HW-1:0]   MinerHashRes_I;
    logic              Found_O;
    logic [NW-1:0]     FoundNonce_O;
    logic [HW-1:0]     FoundHash_O;
    logic              Busy_O;
    logic [31:0]       DispatchCount_O;
    logic              Irq_O;

    int    checks;
    int    failures;
    disp_t sb[$];
    disp_t got;

    miner_scheduler #(.NUM_MINERS(N), .NONCE_W(NW), .HASH_W(HW)) dut (
        .Clk(Clk), .Rst(Rst), .Start_I(Start_I), .Abort_I(Abort_I),
        .BaseNonce_I(BaseNonce_I), .Step_I(Step_I), .MaxDispatch_I(MaxDispatch_I),
        .MinerStart_O(MinerStart_O), .MinerNonce_O(MinerNonce_O), .MinerClear_O(MinerClear_O),
        .MinerDone_I(MinerDone_I), .MinerFound_I(MinerFound_I),
        .MinerNonceRes_I(MinerNonceRes_I), .MinerHashRes_I(MinerHashRes_I),
        .Found_O(Found_O), .FoundNonce_O(FoundNonce_O), .FoundHash_O(FoundHash_O),
        .Busy_O(Busy_O), .DispatchCount_O(DispatchCount_O), .Irq_O(Irq_O)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [N-1:0] s, input logic [NW-1:0] n);
        disp_t d;
        d.start = s;
        d.nonce = n;
        sb.push_back(d);
    endtask

    // Advance one edge, then compare any dispatch against the scoreboard head.
    task automatic cyc();
        @(posedge Clk);
        #1;
        if (MinerStart_O !== '0) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_dispatch observed=%0h expected=none", MinerStart_O);
            end
            if (sb.size() != 0) begin
                got = sb.pop_front();
                chk("dispatch_start", 256'(MinerStart_O), 256'(got.start));
                chk("dispatch_nonce", 256'(MinerNonce_O), 256'(got.nonce));
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        Clk = 1'b0; Rst = 1'b1; Start_I = 1'b0; Abort_I = 1'b0;
        BaseNonce_I = '0; Step_I = '0; MaxDispatch_I = '0;
        MinerDone_I = '0; MinerFound_I = '0; MinerNonceRes_I = '0; MinerHashRes_I = '0;
        cyc(); cyc();
        chk("rst_start", 256'(MinerStart_O), 256'(0));
        chk("rst_clear", 256'(MinerClear_O), 256'(0));
        chk("rst_found", 256'(Found_O), 256'(0));
        chk("rst_busy", 256'(Busy_O), 256'(0));
        chk("rst_irq", 256'(Irq_O), 256'(0));
        chk("rst_nonce", 256'(MinerNonce_O), 256'(0));
        chk("rst_fnonce", 256'(FoundNonce_O), 256'(0));
        chk("rst_fhash", 256'(FoundHash_O), 256'(0));
        chk("rst_count", 256'(DispatchCount_O), 256'(0));
        Rst = 1'b0;

        // Job 1: four back-to-back dispatches from 0x10
        Start_I = 1'b1; BaseNonce_I = NW'(16'h10); Step_I = 32'd1; MaxDispatch_I = 32'd0;
        push(4'b0001, NW'(16'h10)); push(4'b0010, NW'(16'h11));
        push(4'b0100, NW'(16'h12)); push(4'b1000, NW'(16'h13));
        cyc(); Start_I = 1'b0;
        chk("busy_after_start", 256'(Busy_O), 256'(1));
        chk("no_start_edge1", 256'(MinerStart_O), 256'(0));
        cyc();
        chk("no_start_edge2", 256'(MinerStart_O), 256'(0));
        repeat (4) cyc();
        chk("count_4", 256'(DispatchCount_O), 256'(4));
        chk("sb_empty_1", 256'(sb.size()), 256'(0));
        cyc();
        chk("all_busy_idle", 256'(MinerStart_O), 256'(0));

        // Miner 2 finishes without a find and is refilled one cycle later
        MinerDone_I = 4'b0100; push(4'b0100, NW'(16'h14));
        cyc(); MinerDone_I = '0;
        chk("freed_not_same_edge", 256'(MinerStart_O), 256'(0));
        cyc();
        chk("sb_empty_2", 256'(sb.size()), 256'(0));
        chk("count_5", 256'(DispatchCount_O), 256'(5));

        // Miners 1 and 3 find together: lowest index wins
        MinerNonceRes_I[1*NW +: NW] = NW'(32'hAAAA_0001);
        MinerNonceRes_I[3*NW +: NW] = NW'(32'hBBBB_0003);
        MinerHashRes_I[1*HW +: HW]  = HW'(32'hCAFE_0001);
        MinerHashRes_I[3*HW +: HW]  = HW'(32'hCAFE_0003);
        MinerDone_I = 4'b1010; MinerFound_I = 4'b1010;
        cyc(); MinerDone_I = '0; MinerFound_I = '0;
        chk("found_pulse", 256'(Found_O), 256'(1));
        chk("found_nonce", 256'(FoundNonce_O), 256'(32'hAAAA_0001));
        chk("found_hash", 256'(FoundHash_O), 256'(32'hCAFE_0001));
        chk("found_irq", 256'(Irq_O), 256'(1));
        chk("found_clear", 256'(MinerClear_O), 256'(1));
        chk("found_busy", 256'(Busy_O), 256'(0));
        cyc();
        chk("found_once", 256'(Found_O), 256'(0));
        chk("clear_once", 256'(MinerClear_O), 256'(0));
        chk("irq_sticky", 256'(Irq_O), 256'(1));
        repeat (3) cyc();
        chk("done_no_dispatch", 256'(MinerStart_O), 256'(0));

        // Job 2 from DONE: limit of 6, pointer continues after miner 2
        Start_I = 1'b1; BaseNonce_I = NW'(16'h100); Step_I = 32'd3; MaxDispatch_I = 32'd6;
        push(4'b1000, NW'(16'h100)); push(4'b0001, NW'(16'h103));
        push(4'b0010, NW'(16'h106)); push(4'b0100, NW'(16'h109));
        cyc(); Start_I = 1'b0;
        chk("irq_cleared_by_start", 256'(Irq_O), 256'(0));
        cyc();
        repeat (4) cyc();
        chk("job2_count_4", 256'(DispatchCount_O), 256'(4));
        MinerDone_I = 4'b0001; push(4'b0001, NW'(16'h10C));
        cyc(); MinerDone_I = '0;
        cyc();
        MinerDone_I = 4'b1000; push(4'b1000, NW'(16'h10F));
        cyc(); MinerDone_I = '0;
        cyc();
        chk("job2_count_6", 256'(DispatchCount_O), 256'(6));
        chk("sb_empty_3", 256'(sb.size()), 256'(0));
        MinerDone_I = 4'b0010;
        cyc(); MinerDone_I = '0;
        chk("drain_busy", 256'(Busy_O), 256'(1));
        chk("drain_irq", 256'(Irq_O), 256'(0));
        cyc();
        chk("limit_held", 256'(DispatchCount_O), 256'(6));
        // miner 1 is already idle, so its found flag must be ignored
        MinerNonceRes_I[1*NW +: NW] = NW'(32'hDEAD_0001);
        MinerDone_I = 4'b1111; MinerFound_I = 4'b0010;
        cyc(); MinerDone_I = '0; MinerFound_I = '0;
        chk("exhaust_irq", 256'(Irq_O), 256'(1));
        chk("exhaust_no_found", 256'(Found_O), 256'(0));
        chk("exhaust_busy", 256'(Busy_O), 256'(0));
        chk("exhaust_clear", 256'(MinerClear_O), 256'(1));
        chk("result_held", 256'(FoundNonce_O), 256'(32'hAAAA_0001));
        cyc();
        chk("exhaust_clear_once", 256'(MinerClear_O), 256'(0));

        // Job 3: nonce wrap, then abort with a simultaneous start
        Rst = 1'b1;
        cyc(); Rst = 1'b0;
        chk("rst_irq_2", 256'(Irq_O), 256'(0));
        Start_I = 1'b1; BaseNonce_I = '1; Step_I = 32'd2; MaxDispatch_I = 32'd0;
        push(4'b0001, '1); push(4'b0010, NW'(1));
        cyc(); Start_I = 1'b0;
        cyc(); cyc(); cyc();
        chk("sb_empty_wrap", 256'(sb.size()), 256'(0));
        Abort_I = 1'b1; Start_I = 1'b1; BaseNonce_I = NW'(16'h77);
        cyc(); Abort_I = 1'b0; Start_I = 1'b0;
        chk("abort_clear", 256'(MinerClear_O), 256'(1));
        chk("abort_busy", 256'(Busy_O), 256'(0));
        chk("abort_irq", 256'(Irq_O), 256'(0));
        repeat (4) cyc();
        chk("abort_idle_busy", 256'(Busy_O), 256'(0));
        chk("abort_idle_clear", 256'(MinerClear_O), 256'(0));

        // Reset mid-job drops the work without a clear pulse
        Start_I = 1'b1; BaseNonce_I = NW'(16'h50); Step_I = 32'd1; MaxDispatch_I = 32'd0;
        push(4'b0100, NW'(16'h50));
        cyc(); Start_I = 1'b0;
        cyc(); cyc();
        chk("sb_empty_4", 256'(sb.size()), 256'(0));
        Rst = 1'b1;
        cyc();
        chk("midrst_clear", 256'(MinerClear_O), 256'(0));
        chk("midrst_busy", 256'(Busy_O), 256'(0));
        chk("midrst_count", 256'(DispatchCount_O), 256'(0));
        chk("midrst_nonce", 256'(MinerNonce_O), 256'(0));
        Rst = 1'b0;
        cyc();
        chk("midrst_clear_after", 256'(MinerClear_O), 256'(0));
        chk("midrst_no_dispatch", 256'(MinerStart_O), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
